alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage that sits directly in front of the `alu`. It accepts RV32I integer instructions (OP, OP-IMM, LUI, AUIPC) with register operands already read. It decodes each one into an ALU operation code and the A/B operands, and delivers them to the ALU through a registered valid/ready handshake. A one-entry skid buffer keeps throughput at one instruction per clock under backpressure, with no combinational ready path.

## Interface
- `DATA_WIDTH`, `` `DATA_WIDTH `` (32): operand and PC width.
- `ALU_OP_WIDTH`, 6: width of the ALU operation code.
- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: reset, asynchronous and active-high.
- `i_flush` in 1: synchronous pipeline flush.
- `i_valid` in 1: upstream instruction valid.
- `o_ready` in 1: stage can accept an instruction this cycle (registered).
- `i_instr` in 32: instruction word.
- `i_pc` in DATA_WIDTH: instruction address.
- `i_rs1_data` in DATA_WIDTH: rs1 read data, aligned with `i_instr`.
- `i_rs2_data` in DATA_WIDTH: rs2 read data, aligned with `i_instr`.
- `o_valid` out 1: issued operation valid.
- `i_ready` in 1: ALU/writeback accepts the operation.
- `o_alu_op` out 6: `` `OP_ALU_* `` code.
- `o_a` out DATA_WIDTH: ALU operand A.
- `o_b` out DATA_WIDTH: ALU operand B.
- `o_rd` out 5: destination register.
- `o_we` out 1: writeback enable.
- `o_illegal` out 1: instruction not supported by this stage.

## Operation
- Transfer in occurs when `i_valid && o_ready`. Transfer out occurs when `o_valid && i_ready`.
- Decode mapping:
  - OP `0110011`: ADD/SUB (by funct7[5]), SLL, SLT, XOR, SRL/SRA (by funct7[5]), OR, AND map to the matching `` `OP_ALU_* ``.
  - OP register form: a=rs1_data, b=rs2_data.
  - OP register shifts: b={27'b0, rs2_data[4:0]}.
- OP-IMM `0010011`:
  - ADDI, SLTI, XORI, ORI, ANDI take b=sign-extended imm[11:0].
  - SLLI, SRLI, SRAI take b={27'b0, shamt}.
  - SLLI and SRLI require funct7=0000000. SRAI requires funct7=0100000.
- LUI maps to ADD with a=0, b={imm[31:12], 12'b0}.
- AUIPC maps to ADD with a=i_pc, b={imm[31:12], 12'b0}.
- `` `OP_ALU_INV `` is never generated.
- Illegal instructions (SLTU, SLTIU, bad funct7, any other opcode) still flow through in order with `o_illegal`=1, `o_we`=0, `o_alu_op`=`` `OP_ALU_ADD ``, a=b=0.
- `o_we` = legal && rd!=0.
- Datapath is a main output register plus one skid register of identical width.
  - In and no out while main full: the decoded entry goes to skid. `o_ready` falls the next cycle.
  - Out while skid full: skid moves to main. `o_ready` rises the next cycle.
  - In and out simultaneously with skid empty: the new entry loads main directly.
- Order is strictly preserved. No entry is lost or duplicated.
- `i_flush`: both entries are invalidated at the next edge, and any input accepted that cycle is dropped. `o_ready`=1 and `o_valid`=0 the next cycle. `i_flush` has priority over all other events.

## Timing
- Latency: instruction accepted at edge N appears on outputs after edge N (valid in cycle N+1) when main is empty.
- Throughput is 1/cycle with `i_ready` held high.
- Capacity is 2 entries. `o_ready` is a flop: it equals !skid_full.
- Outputs are stable while `o_valid && !i_ready`.
- Reset (async, any time, including mid-transfer):
  - `o_valid`=0, `o_ready`=1.
  - `o_alu_op`, `o_a`, `o_b`, `o_rd`, `o_we`, `o_illegal` all 0.
  - Both entries are emptied.
- `i_ready` low for K cycles with `i_valid` high: at most 2 entries are held, and `o_ready` is low from the cycle after the skid fills.

## Structure
- The shared defines header holds `DATA_WIDTH`, all `` `OP_ALU_* `` codes (already used by `alu`), and new RV32I opcode/funct3 constants (`OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`).
- Combinational sub-module `alu_decode` (instr, pc, rs1, rs2 → op, a, b, rd, we, illegal). The parent `alu_issue` holds the main/skid registers and handshake logic.

## Test plan
- `0xFFF10093` (ADDI x1,x2,-1), rs1=5 → next cycle: `o_alu_op`=ADD, a=5, b=0xFFFFFFFF, rd=1, we=1, illegal=0.
- `0x402081B3` (SUB x3,x1,x2), rs1=7, rs2=7 → SUB, a=7, b=7, rd=3; the ALU result checked as 0.
- `0x40335293` (SRAI x5,x6,3), rs1=0xFFFFFFF0 → SRA, b=3. Then `0x123453B7` (LUI x7) → ADD, a=0, b=0x12345000, rd=7.
- `0x0020B233` (SLTU) → `o_illegal`=1, we=0, op=ADD, a=b=0, delivered in order between two legal ADDIs.
- Back-to-back ADDIs with imm 1,2,3,4 and `i_ready` low for 3 cycles → `o_ready` low after 2 held, outputs imm 1,2,3,4 in order once `i_ready` rises, none lost.
- Skid full, then `i_flush` pulsed together with `i_valid` → next cycle `o_valid`=0, `o_ready`=1, flushed/dropped entries never appear. Async `i_rst` mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared widths, ALU operation codes, RV32I decode constants
// and the issued-operation record carried through the issue registers.
`default_nettype none

package alu_issue_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ALU_OP_WIDTH = 6;

  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_INV  = 6'd0;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_ADD  = 6'd1;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SUB  = 6'd2;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SLL  = 6'd3;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SLT  = 6'd4;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SLTU = 6'd5;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_XOR  = 6'd6;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SRL  = 6'd7;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SRA  = 6'd8;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_OR   = 6'd9;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_AND  = 6'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic [4:0]              rd;
    logic                    we;
    logic                    illegal;
  } issue_t;

endpackage

`default_nettype wire

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I OP/OP-IMM/LUI/AUIPC decoder producing the
// ALU operation code and operands for one instruction.
`default_nettype none

module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output issue_t                dec_o
);

  logic [6:0]              w_opc;
  logic [2:0]              w_f3;
  logic [6:0]              w_f7;
  logic [DATA_WIDTH-1:0]   w_imm_i;
  logic [DATA_WIDTH-1:0]   w_imm_u;
  logic [DATA_WIDTH-1:0]   w_sh_reg;
  logic [DATA_WIDTH-1:0]   w_sh_imm;
  logic [ALU_OP_WIDTH-1:0] w_op;
  logic [DATA_WIDTH-1:0]   w_a;
  logic [DATA_WIDTH-1:0]   w_b;
  logic                    w_legal;

  assign w_opc    = instr_i[6:0];
  assign w_f3     = instr_i[14:12];
  assign w_f7     = instr_i[31:25];
  assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign w_imm_u  = {instr_i[31:12], 12'b0};
  assign w_sh_reg = {27'b0, rs2_i[4:0]};
  assign w_sh_imm = {27'b0, instr_i[24:20]};

  always_comb begin
    w_op    = OP_ALU_ADD;
    w_a     = rs1_i;
    w_b     = rs2_i;
    w_legal = 1'b0;
    unique case (w_opc)
      OPC_OP: begin
        w_legal = (w_f7 == F7_BASE);
        unique case (w_f3)
          F3_ADD: begin
            w_op    = (w_f7 == F7_ALT) ? OP_ALU_SUB : OP_ALU_ADD;
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          end
          F3_SLL: begin w_op = OP_ALU_SLL; w_b = w_sh_reg; end
          F3_SLT:  w_op = OP_ALU_SLT;
          F3_XOR:  w_op = OP_ALU_XOR;
          F3_SR: begin
            w_op    = (w_f7 == F7_ALT) ? OP_ALU_SRA : OP_ALU_SRL;
            w_b     = w_sh_reg;
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          end
          F3_OR:   w_op = OP_ALU_OR;
          F3_AND:  w_op = OP_ALU_AND;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        w_b     = w_imm_i;
        w_legal = 1'b1;
        unique case (w_f3)
          F3_ADD: w_op = OP_ALU_ADD;
          F3_SLL: begin
            w_op    = OP_ALU_SLL;
            w_b     = w_sh_imm;
            w_legal = (w_f7 == F7_BASE);
          end
          F3_SLT: w_op = OP_ALU_SLT;
          F3_XOR: w_op = OP_ALU_XOR;
          F3_SR: begin
            w_op    = (w_f7 == F7_ALT) ? OP_ALU_SRA : OP_ALU_SRL;
            w_b     = w_sh_imm;
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          end
          F3_OR:   w_op = OP_ALU_OR;
          F3_AND:  w_op = OP_ALU_AND;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        w_a     = '0;
        w_b     = w_imm_u;
        w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_a     = pc_i;
        w_b     = w_imm_u;
        w_legal = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase

    // Unsupported encodings still travel down the pipe as a harmless ADD 0+0.
    if (!w_legal) begin
      w_op = OP_ALU_ADD;
      w_a  = '0;
      w_b  = '0;
    end
  end

  assign dec_o.op      = w_op;
  assign dec_o.a       = w_a;
  assign dec_o.b       = w_b;
  assign dec_o.rd      = instr_i[11:7];
  assign dec_o.we      = w_legal && (instr_i[11:7] != 5'd0);
  assign dec_o.illegal = !w_legal;

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage in front of the ALU; registered
// valid/ready output with a one-entry skid buffer and synchronous flush.
`default_nettype none

module alu_issue
  import alu_issue_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [31:0]             i_instr,
  input  logic [DATA_WIDTH-1:0]   i_pc,
  input  logic [DATA_WIDTH-1:0]   i_rs1_data,
  input  logic [DATA_WIDTH-1:0]   i_rs2_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op,
  output logic [DATA_WIDTH-1:0]   o_a,
  output logic [DATA_WIDTH-1:0]   o_b,
  output logic [4:0]              o_rd,
  output logic                    o_we,
  output logic                    o_illegal
);

  issue_t w_dec;
  issue_t main_q, main_d;
  issue_t skid_q, skid_d;
  logic   main_v_q, main_v_d;
  logic   skid_v_q, skid_v_d;
  logic   ready_q, ready_d;
  logic   w_in, w_out;

  alu_decode u_decode (
    .instr_i (i_instr),
    .pc_i    (i_pc),
    .rs1_i   (i_rs1_data),
    .rs2_i   (i_rs2_data),
    .dec_o   (w_dec)
  );

  assign w_in  = i_valid && ready_q;
  assign w_out = main_v_q && i_ready;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (i_flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (w_in) begin
        main_d   = w_dec;
        main_v_d = 1'b1;
      end
    end else if (w_out) begin
      // ready_q is low whenever skid is full, so no new entry can arrive here.
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (w_in) begin
        main_d = w_dec;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (w_in) begin
      skid_d   = w_dec;
      skid_v_d = 1'b1;
    end
    ready_d = !skid_v_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = main_v_q;
  assign o_alu_op  = main_q.op;
  assign o_a       = main_q.a;
  assign o_b       = main_q.b;
  assign o_rd      = main_q.rd;
  assign o_we      = main_q.we;
  assign o_illegal = main_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors with a queue scoreboard; a negedge monitor
// pushes expectations on accept and pops/compares on each issued operation.
`default_nettype none

module tb_alu_issue;
  import alu_issue_pkg::*;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_instr = '0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic        o_ready, o_valid, o_we, o_illegal;
  logic [5:0]  o_alu_op;
  logic [31:0] o_a, o_b;
  logic [4:0]  o_rd;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_rs1_data (i_rs1),
    .i_rs2_data (i_rs2),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_alu_op   (o_alu_op),
    .o_a        (o_a),
    .o_b        (o_b),
    .o_rd       (o_rd),
    .o_we       (o_we),
    .o_illegal  (o_illegal)
  );

  function automatic exp_t mk(input logic [5:0] op, input logic [31:0] a, b,
                              input logic [4:0] rd, input logic we, ill);
    mk = '{op: op, a: a, b: b, rd: rd, we: we, ill: ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: inputs change only just after posedge, so negedge sees what the next edge will do.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_flush) begin
        sb.delete();
      end else begin
        if (o_valid && i_ready) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue: got op=%0d a=0x%08h b=0x%08h rd=%0d expected nothing",
                     o_alu_op, o_a, o_b, o_rd);
          end else begin
            exp_t e;
            logic ok;
            e  = sb.pop_front();
            ok = (o_alu_op === e.op) && (o_a === e.a) && (o_b === e.b) &&
                 (o_we === e.we) && (o_illegal === e.ill) && (e.ill || (o_rd === e.rd));
            if (!ok) begin
              n_fail++;
              $display("FAIL issue: got op=%0d a=0x%08h b=0x%08h rd=%0d we=%0b ill=%0b expected op=%0d a=0x%08h b=0x%08h rd=%0d we=%0b ill=%0b",
                       o_alu_op, o_a, o_b, o_rd, o_we, o_illegal,
                       e.op, e.a, e.b, e.rd, e.we, e.ill);
            end
          end
        end
        if (i_valid && o_ready) sb.push_back(cur_exp);
      end
    end
  end

  task automatic send(input logic [31:0] ins, pc, r1, r2, input exp_t e);
    logic acc;
    acc     = 1'b0;
    i_instr = ins;
    i_pc    = pc;
    i_rs1   = r1;
    i_rs2   = r2;
    cur_exp = e;
    i_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got o_ready=0 expected 1 for instr 0x%08h", ins);
    end
  endtask

  task automatic drain();
    logic done;
    done    = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !o_valid) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: got %0d entries outstanding expected 0", sb.size());
    end
  endtask

  function automatic logic [31:0] addi_x1(input logic [11:0] imm);
    addi_x1 = {imm, 20'h00093};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_op", {26'b0, o_alu_op}, 32'd0);
    chk("rst_a", o_a, 32'd0);
    chk("rst_b", o_b, 32'd0);
    chk("rst_rd_we_ill", {25'b0, o_rd, o_we, o_illegal}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming decode vectors at full throughput.
    i_ready = 1'b1;
    send(32'hFFF10093, 0, 32'd5, 0, mk(OP_ALU_ADD, 32'd5, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
    send(32'h402081B3, 0, 32'd7, 32'd7, mk(OP_ALU_SUB, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0));
    send(32'h40335293, 0, 32'hFFFFFFF0, 0, mk(OP_ALU_SRA, 32'hFFFFFFF0, 32'd3, 5'd5, 1'b1, 1'b0));
    send(32'h123453B7, 0, 32'hDEADBEEF, 0, mk(OP_ALU_ADD, 32'd0, 32'h12345000, 5'd7, 1'b1, 1'b0));
    send(32'h00001517, 32'h80000000, 32'd1, 0, mk(OP_ALU_ADD, 32'h80000000, 32'h00001000, 5'd10, 1'b1, 1'b0));
    send(32'h00209233, 0, 32'h11, 32'hFFFFFF25, mk(OP_ALU_SLL, 32'h11, 32'd5, 5'd4, 1'b1, 1'b0));
    send(32'h00508013, 0, 32'd9, 0, mk(OP_ALU_ADD, 32'd9, 32'd5, 5'd0, 1'b0, 1'b0));
    send(32'h0020B233, 0, 32'd3, 32'd4, mk(OP_ALU_ADD, 32'd0, 32'd0, 5'd4, 1'b0, 1'b1));
    send(32'hFFF10093, 0, 32'd5, 0, mk(OP_ALU_ADD, 32'd5, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
    send(32'h40009093, 0, 32'd1, 0, mk(OP_ALU_ADD, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1));
    send(32'h7FF1C113, 0, 32'hF0F0F0F0, 0, mk(OP_ALU_XOR, 32'hF0F0F0F0, 32'h7FF, 5'd2, 1'b1, 1'b0));
    send(32'h01F3D313, 0, 32'h80000000, 0, mk(OP_ALU_SRL, 32'h80000000, 32'd31, 5'd6, 1'b1, 1'b0));
    send(32'h00000073, 0, 32'd1, 32'd2, mk(OP_ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
    drain();

    // Backpressure: two entries held, ready drops, order kept on release.
    i_ready = 1'b0;
    send(addi_x1(12'd1), 0, 0, 0, mk(OP_ALU_ADD, 0, 32'd1, 5'd1, 1'b1, 1'b0));
    chk("latency_valid", {31'b0, o_valid}, 32'd1);
    chk("one_held_ready", {31'b0, o_ready}, 32'd1);
    send(addi_x1(12'd2), 0, 0, 0, mk(OP_ALU_ADD, 0, 32'd2, 5'd1, 1'b1, 1'b0));
    chk("skid_full_ready", {31'b0, o_ready}, 32'd0);
    cur_exp = mk(OP_ALU_ADD, 0, 32'd3, 5'd1, 1'b1, 1'b0);
    i_instr = addi_x1(12'd3);
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_ready", {31'b0, o_ready}, 32'd0);
    chk("stall_stable_b", o_b, 32'd1);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send(addi_x1(12'd3), 0, 0, 0, mk(OP_ALU_ADD, 0, 32'd3, 5'd1, 1'b1, 1'b0));
    send(addi_x1(12'd4), 0, 0, 0, mk(OP_ALU_ADD, 0, 32'd4, 5'd1, 1'b1, 1'b0));
    drain();

    // Flush with skid full and an input presented in the same cycle.
    i_ready = 1'b0;
    send(addi_x1(12'd9), 0, 0, 0, mk(OP_ALU_ADD, 0, 32'd9, 5'd1, 1'b1, 1'b0));
    send(addi_x1(12'd10), 0, 0, 0, mk(OP_ALU_ADD, 0, 32'd10, 5'd1, 1'b1, 1'b0));
    cur_exp = mk(OP_ALU_ADD, 0, 32'd12, 5'd1, 1'b1, 1'b0);
    i_instr = addi_x1(12'd12);
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_valid", {31'b0, o_valid}, 32'd0);
    chk("flush_ready", {31'b0, o_ready}, 32'd1);
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(addi_x1(12'd11), 0, 0, 0, mk(OP_ALU_ADD, 0, 32'd11, 5'd1, 1'b1, 1'b0));
    drain();

    // Asynchronous reset mid-cycle with both entries occupied.
    i_ready = 1'b0;
    send(32'h40335293, 0, 32'hFFFFFFF0, 0, mk(OP_ALU_SRA, 32'hFFFFFFF0, 32'd3, 5'd5, 1'b1, 1'b0));
    send(32'h123453B7, 0, 0, 0, mk(OP_ALU_ADD, 32'd0, 32'h12345000, 5'd7, 1'b1, 1'b0));
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("arst_valid", {31'b0, o_valid}, 32'd0);
    chk("arst_ready", {31'b0, o_ready}, 32'd1);
    chk("arst_op", {26'b0, o_alu_op}, 32'd0);
    chk("arst_a", o_a, 32'd0);
    chk("arst_b", o_b, 32'd0);
    chk("arst_rd_we_ill", {25'b0, o_rd, o_we, o_illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0020B233, 0, 32'd3, 32'd4, mk(OP_ALU_ADD, 32'd0, 32'd0, 5'd4, 1'b0, 1'b1));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
